// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial ALU datapath.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice_1bit.sv
// One-bit ALU slice: op[2] inverts b, op[1:0] picks AND/OR/SUM/XOR; carry chain is always live.
module alu_slice_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    logic bb;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bb   = b ^ op[2];
        r    = 1'b0;
        cout = (a & bb) | ((a ^ bb) & c);
        case (op[1:0])
            OP_AND[1:0]: r = a & bb;
            OP_OR[1:0]:  r = a | bb;
            OP_ADD[1:0]: r = a ^ bb ^ c;
            default:     r = a ^ bb;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Runs a WIDTH-bit ALU op through one 1-bit slice, LSB first, with valid/ready on both sides.
module bit_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             slice_r;
    logic             slice_cout;
    logic             last_bit;

    alu_slice_1bit u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry),
        .op   (op_q),
        .r    (slice_r),
        .cout (slice_cout)
    );

    assign res_next   = {slice_r, res[WIDTH-1:1]};
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    assign out_result = res;

    // NOTE: sequential state uses non-blocking assignments only; the shift registers are
    // ordinary flops cleared by reset because the cleared result is visible on out_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            op_q      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            out_zero  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= in_a;
                        b_sh     <= in_b;
                        op_q     <= in_op;
                        cnt      <= '0;
                        carry    <= in_op[2];
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    carry <= slice_cout;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB at this point
                        out_zero  <= (res_next == '0);
                        out_cout  <= slice_cout;
                        out_ovf   <= carry ^ slice_cout;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl at WIDTH=8 with hand-computed directed vectors.
module tb_bit_serial_alu_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_cout;
    logic             out_ovf;

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] result;
        logic       zero;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] result;
        logic       zero;
        logic       cout;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Present an op, wait (bounded) for acceptance, and log the expected response.
    task automatic send(input vec_t v, output int acc);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_op    = v.op;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now({v.name, "_accept"});
            in_valid = 1'b0;
            acc      = -1;
            return;
        end
        acc      = cyc + 1;
        e.name   = v.name;
        e.result = v.result;
        e.zero   = v.zero;
        e.cout   = v.cout;
        e.ovf    = v.ovf;
        e.acc    = acc;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) fail_now(name);
    endtask

    // Monitor: latency check on out_valid rise, full compare on each output handshake.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && !prev_v) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid: got 1 expected 0");
            end else begin
                check({sb[0].name, "_latency"}, cyc, sb[0].acc + WIDTH);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h expected none", out_result);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, out_result, e.result);
                check({e.name, "_zero"},   out_zero,   e.zero);
                check({e.name, "_cout"},   out_cout,   e.cout);
                check({e.name, "_ovf"},    out_ovf,    e.ovf);
            end
        end
        prev_v = (out_valid === 1'b1);
    end

    vec_t vecs[7] = '{
        '{"add_ff_01",  3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0},
        '{"sub_80_01",  3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1},
        '{"sub_05_05",  3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0},
        '{"and_f0_3c",  3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1, 1'b0},
        '{"or_a0_0a",   3'b001, 8'hA0, 8'h0A, 8'hAA, 1'b0, 1'b0, 1'b0},
        '{"xor_aa_ff",  3'b011, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b0},
        '{"xnor_0f_0f", 3'b111, 8'h0F, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0}
    };

    vec_t v_b2b_0   = '{"b2b_7f_01",   3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vec_t v_b2b_1   = '{"b2b_10_20",   3'b010, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};
    vec_t v_hold    = '{"hold_sub",    3'b110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    vec_t v_after   = '{"andn_ff_0f",  3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0};
    vec_t v_post_rst = '{"add_01_02",  3'b010, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};

    initial begin
        int acc0;
        int acc1;
        int hs_cyc;
        int waited;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #1;
        check("reset_in_ready",  in_ready,   1);
        check("reset_out_valid", out_valid,  0);
        check("reset_result",    out_result, 0);
        check("reset_flags",     {out_zero, out_cout, out_ovf}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) send(vecs[i], acc0);

        send(v_b2b_0, acc0);
        send(v_b2b_1, acc1);
        check("b2b_spacing", acc1 - acc0, 10);

        // Backpressure: result must hold steady and input side stay closed.
        drain("drain_before_hold");
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(v_hold, acc0);
        waited = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (out_valid !== 1'b1) fail_now("hold_out_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_result",    out_result, 8'hFE);
            check("hold_flags",     {out_zero, out_cout, out_ovf}, 0);
            check("hold_in_ready",  in_ready,  0);
            check("hold_out_valid", out_valid, 1);
            @(negedge clk);
        end
        fork
            send(v_after, acc1);
            begin
                @(posedge clk);
                #1 out_ready = 1'b1;
                hs_cyc = cyc + 1;
            end
        join
        check("accept_after_handshake", acc1 - hs_cyc, 1);

        // Abort an op mid-RUN with reset, then confirm a clean follow-up op.
        drain("drain_before_abort");
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_op    = 3'b010;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) fail_now("abort_accept");
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid,  0);
        check("abort_in_ready",  in_ready,   1);
        check("abort_result",    out_result, 0);
        check("abort_flags",     {out_zero, out_cout, out_ovf}, 0);
        @(negedge clk);
        reset = 1'b0;
        send(v_post_rst, acc0);

        drain("final_drain");
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
